// File: rtl/usb_in_packetizer_if.sv
// FIFO read side and PHY-bound byte stream of the IN-endpoint packetizer.
interface usb_in_packetizer_if;
    logic [7:0] fifo_rddata;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport master (
        input  fifo_rddata,
        input  fifo_empty,
        input  tx_ready,
        output fifo_rd_en,
        output tx_data,
        output tx_valid,
        output tx_last
    );

    modport slave (
        output fifo_rddata,
        output fifo_empty,
        output tx_ready,
        input  fifo_rd_en,
        input  tx_data,
        input  tx_valid,
        input  tx_last
    );
endinterface

// File: rtl/usb_in_packetizer.sv
// USB IN-endpoint transmitter: drains the byte FIFO into one
// PID/payload/CRC16 packet per IN token, tracking DATA0/DATA1.
module usb_in_packetizer #(
    parameter int MAX_PKT = 64,
    parameter int CNT_W   = $clog2(MAX_PKT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_token,
    input  logic in_ack,
    output logic busy,
    usb_in_packetizer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, PID, PRIME, DATA, CRC_LO, CRC_HI
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      crc;
    logic             toggle;
    logic             sent;
    logic [7:0]       tx_q;
    logic             valid_q;
    logic             last_q;
    logic             accept;

    function automatic logic [15:0] crc_upd(
        input logic [15:0] c,
        input logic [7:0]  d
    );
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i])
                r = (r >> 1) ^ 16'hA001;
            else
                r = r >> 1;
        end
        return r;
    endfunction

    assign accept = valid_q & bus.tx_ready;

    // Payload bytes come straight from the FIFO head, which holds still
    // until the byte is accepted and popped.
    assign bus.tx_data    = (state == DATA) ? bus.fifo_rddata : tx_q;
    assign bus.tx_valid   = valid_q;
    assign bus.tx_last    = last_q;
    assign bus.fifo_rd_en = (state == DATA) & accept & ~bus.fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            crc     <= 16'hFFFF;
            toggle  <= 1'b0;
            sent    <= 1'b0;
            tx_q    <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // An ACK only counts once per packet actually sent.
            if (in_ack && !busy && sent) begin
                toggle <= ~toggle;
                sent   <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (in_token) begin
                        state   <= PID;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        crc     <= 16'hFFFF;
                        tx_q    <= toggle ? 8'h4B : 8'hC3;
                        valid_q <= 1'b1;
                    end
                end
                PID: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        state   <= PRIME;
                    end
                end
                PRIME: begin
                    valid_q <= 1'b1;
                    if (bus.fifo_empty || cnt == CNT_W'(MAX_PKT)) begin
                        tx_q  <= ~crc[7:0];
                        state <= CRC_LO;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        crc     <= crc_upd(crc, bus.fifo_rddata);
                        cnt     <= cnt + 1'b1;
                        valid_q <= 1'b0;
                        state   <= PRIME;
                    end
                end
                CRC_LO: begin
                    if (accept) begin
                        tx_q   <= ~crc[15:8];
                        last_q <= 1'b1;
                        state  <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy    <= 1'b0;
                        sent    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
